// File: rtl/requan_wb_fifo.sv
// requan_wb_fifo: writeback buffer between the requantizer datapath and the
// activation/SRAM writeback port. Each incoming lane is narrowed from IN_W to
// OUT_W bits on the write side. Up to DEPTH narrowed vectors are queued.
// The buffer also takes a global pipeline stall and a synchronous flush.
//
// Build option: define REQUAN_WB_CLAMP_EN to signed-saturate each lane to
// OUT_W bits. Without it, each lane is truncated to its low OUT_W bits.
module requan_wb_fifo #(
  parameter int LANES = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES*IN_W-1:0]    in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*OUT_W-1:0]   out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int VW = LANES*OUT_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [VW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [VW-1:0] wdata_s;
  logic          push_s;
  logic          pop_s;

`ifdef REQUAN_WB_CLAMP_EN
  // Signed saturation: in range only when the bits from the sign bit down to
  // bit OUT_W-1 all agree. Otherwise, clip toward the sign of the input.
  function automatic logic [OUT_W-1:0] clamp_lane(input logic [IN_W-1:0] v);
    logic [IN_W-OUT_W:0] upper;
    upper = v[IN_W-1:OUT_W-1];
    if ((&upper) || (~|upper)) begin
      return v[OUT_W-1:0];
    end else if (v[IN_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wdata_s[i*OUT_W +: OUT_W] = clamp_lane(in_data_i[i*IN_W +: IN_W]);
  end
`else
  // Wrap-around narrowing: keep the low OUT_W bits of each lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wdata_s[i*OUT_W +: OUT_W] = in_data_i[i*IN_W +: OUT_W];
    if (OUT_W < IN_W) begin : g_drop
      logic unused_hi_bits;
      assign unused_hi_bits = ^in_data_i[i*IN_W+OUT_W +: IN_W-OUT_W];
    end
  end
`endif

  // Handshake outputs depend only on registered occupancy plus stall/flush.
  assign in_ready_o  = !stall_i && !flush_i && (count_q != FULL_CNT);
  assign out_valid_o = !stall_i && (count_q != '0);
  assign out_data_o  = (count_q != '0) ? mem_q[rp_q] : '0;
  assign count_o     = count_q;

  assign push_s = in_valid_i && in_ready_o;
  assign pop_s  = out_valid_o && out_ready_i;

  // Next-state pointers and occupancy. Flush wins over any transfer.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wp_d = wp_q + AW'(1);
      end else begin
        wp_d = wp_q;
      end
      if (pop_s) begin
        rp_d = rp_q + AW'(1);
      end else begin
        rp_d = rp_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers. Reset discards all entries at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage. It is written only on an accepted push and is never cleared.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wp_q] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_requan_wb_fifo.sv
// Self-checking bench for requan_wb_fifo. A queue holds the expected narrowed
// vectors and acts as a reference model of the FIFO contents.
module tb_requan_wb_fifo;

  localparam int LANES = 4;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int DWI   = LANES*IN_W;
  localparam int DWO   = LANES*OUT_W;

  logic           clk;
  logic           rst;
  logic           stall;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DWI-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DWO-1:0] out_data;
  logic [CW-1:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [DWO-1:0] sb[$];

  requan_wb_fifo #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference narrowing, computed with integer arithmetic
  function automatic logic [OUT_W-1:0] model_lane(input logic [IN_W-1:0] v);
    longint s;
    longint hi;
    longint lo;
    s  = longint'(signed'(v));
    hi = (64'sd1 <<< (OUT_W-1)) - 64'sd1;
    lo = -hi - 64'sd1;
`ifdef REQUAN_WB_CLAMP_EN
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`endif
    return s[OUT_W-1:0];
  endfunction

  function automatic logic [DWO-1:0] model_vec(input logic [DWI-1:0] d);
    logic [DWO-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*OUT_W +: OUT_W] = model_lane(d[i*IN_W +: IN_W]);
    return r;
  endfunction

  function automatic logic [DWI-1:0] rnd_vec();
    logic [DWI-1:0] r;
    for (int i = 0; i < DWI; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, compare the outputs with the model, then update the model
  task automatic drive_cycle(input logic iv, input logic [DWI-1:0] d, input logic ordy,
                             input logic stl, input logic fl);
    logic exp_ir;
    logic exp_ov;
    logic [DWO-1:0] exp_od;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; stall = stl; flush = fl;
    #1;
    exp_ir = !stl && !fl && (sb.size() != DEPTH);
    exp_ov = !stl && (sb.size() != 0);
    exp_od = (sb.size() != 0) ? sb[0] : '0;
    checks++;
    if (in_ready !== exp_ir) begin
      failures++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ir);
    end
    checks++;
    if (out_valid !== exp_ov) begin
      failures++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_ov);
    end
    checks++;
    if (out_data !== exp_od) begin
      failures++; $display("FAIL out_data t=%0t got=%h exp=%h", $time, out_data, exp_od);
    end
    checks++;
    if (count !== CW'(sb.size())) begin
      failures++; $display("FAIL count t=%0t got=%0d exp=%0d", $time, count, sb.size());
    end
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_ov && ordy) void'(sb.pop_front());
      if (exp_ir && iv) sb.push_back(model_vec(d));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || count !== '0) begin
      failures++;
      $display("FAIL reset_state got ir=%b ov=%b od=%h cnt=%0d exp ir=1 ov=0 od=0 cnt=0",
               in_ready, out_valid, out_data, count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; #2;
    rst = 1'b1; #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d ov=%b od=%h exp cnt=0 ov=0 od=0", count, out_valid, out_data);
    end
    sb.delete();
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_narrowing();
    logic [DWI-1:0] d;
    logic [DWO-1:0] exp_c;
    d = {16'hFF80, 16'h0042, 16'hFF00, 16'h0123};
`ifdef REQUAN_WB_CLAMP_EN
    exp_c = {8'h80, 8'h42, 8'h80, 8'h7F};
`else
    exp_c = {8'h80, 8'h42, 8'h00, 8'h23};
`endif
    drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_c) begin
      failures++; $display("FAIL narrowing got ov=%b od=%h exp ov=1 od=%h", out_valid, out_data, exp_c);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      failures++; $display("FAIL full got cnt=%0d ir=%b exp cnt=%0d ir=0", count, in_ready, DEPTH);
    end
    drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(DEPTH)) begin
      failures++; $display("FAIL fifth_push got cnt=%0d exp=%0d", count, DEPTH);
    end
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(DEPTH-1)) begin
      failures++; $display("FAIL wrap_steady got cnt=%0d exp=%0d", count, DEPTH-1);
    end
  endtask

  task automatic test_simul_push_pop();
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(2)) begin
      failures++; $display("FAIL simul_cnt2 got=%0d exp=2", count);
    end
    drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(DEPTH-1)) begin
      failures++; $display("FAIL full_push_pop got=%0d exp=%0d", count, DEPTH-1);
    end
  endtask

  task automatic test_stall();
    logic [DWO-1:0] head;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    head = sb[0];
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (count !== CW'(2) || out_data !== head) begin
      failures++; $display("FAIL stall_hold got cnt=%0d od=%h exp cnt=2 od=%h", count, out_data, head);
    end
    drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== CW'(2) || out_data === head) begin
      failures++; $display("FAIL stall_resume got cnt=%0d od=%h exp cnt=2 and head advanced", count, out_data);
    end
  endtask

  task automatic test_flush();
    logic [DWI-1:0] d;
    drive_cycle(1'b1, rnd_vec(), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush got cnt=%0d ov=%b exp cnt=0 ov=0", count, out_valid);
    end
    d = rnd_vec();
    drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== model_vec(d)) begin
      failures++; $display("FAIL post_flush_push got ov=%b od=%h exp ov=1 od=%h", out_valid, out_data, model_vec(d));
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 60; i++)
      drive_cycle(1'($urandom_range(0, 1)), rnd_vec(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_narrowing();
    test_fill_wrap();
    test_simul_push_pop();
    test_stall();
    test_flush();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
